// File: rtl/pipeline_hazard_ctrl.sv
// Hazard and freeze sequencer for the 5-stage pipeline registers of the RV64 core.
// Outputs are combinational from the current state and inputs; state and counters are registered.
module pipeline_hazard_ctrl #(
    parameter int MAX_WAIT = 64,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_uses_rs2,
    input  logic [4:0]       ex_rd,
    input  logic             ex_MemRead,
    input  logic             ex_branch_taken,
    input  logic             mem_busy,
    output logic             pc_write,
    output logic             if_id_write,
    output logic             if_id_flush,
    output logic             id_ex_write,
    output logic             id_ex_flush,
    output logic             ex_mem_write,
    output logic             mem_wb_flush,
    output logic             pipe_error,
    output logic [CNT_W-1:0] stall_cycles
);

    localparam int WAIT_W = $clog2(MAX_WAIT + 1);

    localparam logic [1:0] ST_RUN      = 2'd0;
    localparam logic [1:0] ST_MEM_WAIT = 2'd1;
    localparam logic [1:0] ST_ERR      = 2'd2;

    localparam logic [WAIT_W-1:0] WAIT_ONE = WAIT_W'(1);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_WAIT);

    logic [1:0]        state_reg, state_next;
    logic [WAIT_W-1:0] wait_cnt_reg, wait_cnt_next;
    logic [WAIT_W-1:0] wait_inc;
    logic [CNT_W-1:0]  stall_cnt_reg;
    logic              load_use;
    logic              in_err;

    // rs2 comparison is gated by id_uses_rs2 so a don't-care rs2 field never stalls.
    assign load_use = ex_MemRead && (ex_rd != 5'd0) &&
                      ((ex_rd == id_rs1) || (id_uses_rs2 && (ex_rd == id_rs2)));

    assign in_err   = (state_reg == ST_ERR);
    assign wait_inc = wait_cnt_reg + WAIT_ONE;

    always_comb begin
        state_next    = state_reg;
        wait_cnt_next = wait_cnt_reg;
        case (state_reg)
            ST_RUN: begin
                if (mem_busy) begin
                    wait_cnt_next = WAIT_ONE;
                    state_next    = (WAIT_ONE == WAIT_MAX) ? ST_ERR : ST_MEM_WAIT;
                end
            end
            ST_MEM_WAIT: begin
                if (mem_busy) begin
                    wait_cnt_next = wait_inc;
                    if (wait_inc == WAIT_MAX) begin
                        state_next = ST_ERR;
                    end
                end else begin
                    wait_cnt_next = '0;
                    state_next    = ST_RUN;
                end
            end
            ST_ERR: begin
                state_next = ST_ERR;
            end
            default: begin
                state_next    = ST_RUN;
                wait_cnt_next = '0;
            end
        endcase
    end

    // Priority: error, memory freeze, branch redirect, load-use stall.
    always_comb begin
        pc_write     = 1'b1;
        if_id_write  = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_write  = 1'b1;
        id_ex_flush  = 1'b0;
        ex_mem_write = 1'b1;
        mem_wb_flush = 1'b0;
        if (in_err) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_write  = 1'b0;
            ex_mem_write = 1'b0;
            mem_wb_flush = 1'b1;
        end else if (mem_busy) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_write  = 1'b0;
            ex_mem_write = 1'b0;
            mem_wb_flush = 1'b1;
        end else if (ex_branch_taken) begin
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
        end else if (load_use) begin
            pc_write    = 1'b0;
            if_id_write = 1'b0;
            id_ex_flush = 1'b1;
        end
    end

    assign pipe_error   = in_err;
    assign stall_cycles = stall_cnt_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= ST_RUN;
            wait_cnt_reg  <= '0;
            stall_cnt_reg <= '0;
        end else begin
            state_reg    <= state_next;
            wait_cnt_reg <= wait_cnt_next;
            if (!pc_write && (stall_cnt_reg != {CNT_W{1'b1}})) begin
                stall_cnt_reg <= stall_cnt_reg + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench for pipeline_hazard_ctrl: stimulus pushes expected controls per cycle,
// a negedge monitor pops and compares against the DUT outputs.
module tb_pipeline_hazard_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  id_rs1, id_rs2, ex_rd;
    logic        id_uses_rs2, ex_MemRead, ex_branch_taken, mem_busy;
    logic        pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_flush;
    logic        ex_mem_write, mem_wb_flush, pipe_error;
    logic [15:0] stall_cycles;

    pipeline_hazard_ctrl #(.MAX_WAIT(64), .CNT_W(16)) dut (
        .clk             (clk),
        .rst             (rst),
        .id_rs1          (id_rs1),
        .id_rs2          (id_rs2),
        .id_uses_rs2     (id_uses_rs2),
        .ex_rd           (ex_rd),
        .ex_MemRead      (ex_MemRead),
        .ex_branch_taken (ex_branch_taken),
        .mem_busy        (mem_busy),
        .pc_write        (pc_write),
        .if_id_write     (if_id_write),
        .if_id_flush     (if_id_flush),
        .id_ex_write     (id_ex_write),
        .id_ex_flush     (id_ex_flush),
        .ex_mem_write    (ex_mem_write),
        .mem_wb_flush    (mem_wb_flush),
        .pipe_error      (pipe_error),
        .stall_cycles    (stall_cycles)
    );

    always #5 clk = ~clk;

    // {pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_flush, ex_mem_write, mem_wb_flush, pipe_error}
    localparam logic [7:0] V_IDLE   = 8'b1101_0100;
    localparam logic [7:0] V_FREEZE = 8'b0000_0010;
    localparam logic [7:0] V_BRANCH = 8'b1111_1100;
    localparam logic [7:0] V_LOAD   = 8'b0001_1100;
    localparam logic [7:0] V_ERR    = 8'b0000_0011;

    typedef struct {
        string       name;
        logic [7:0]  ctl;
        logic [15:0] stall;
    } exp_t;

    exp_t        sb[$];
    int          n_checks = 0;
    int          n_pass   = 0;
    logic [15:0] exp_stall = 16'd0;

    // Drive one cycle of inputs, queue its expected response, then advance one clock.
    task automatic step(input string nm, input logic [7:0] ctl,
                        input logic busy, input logic br, input logic mr,
                        input logic [4:0] rd, input logic [4:0] rs1,
                        input logic [4:0] rs2, input logic u2);
        exp_t e;
        mem_busy        = busy;
        ex_branch_taken = br;
        ex_MemRead      = mr;
        ex_rd           = rd;
        id_rs1          = rs1;
        id_rs2          = rs2;
        id_uses_rs2     = u2;
        e.name  = nm;
        e.ctl   = ctl;
        e.stall = exp_stall;
        sb.push_back(e);
        if (!ctl[7] && exp_stall != 16'hFFFF) exp_stall = exp_stall + 16'd1;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input string nm);
        step(nm, V_IDLE, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
    endtask

    // Monitor: compare whatever expectation is pending at each falling edge.
    initial begin
        exp_t e;
        logic [7:0] act;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e   = sb.pop_front();
                act = {pc_write, if_id_write, if_id_flush, id_ex_write,
                       id_ex_flush, ex_mem_write, mem_wb_flush, pipe_error};
                n_checks++;
                if (act === e.ctl) n_pass++;
                else $display("FAIL %s ctl: got %b want %b", e.name, act, e.ctl);
                n_checks++;
                if (stall_cycles === e.stall) n_pass++;
                else $display("FAIL %s stall_cycles: got %0d want %0d", e.name, stall_cycles, e.stall);
                $display("txn %s ctl=%b stall=%0d", e.name, act, stall_cycles);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1;
        mem_busy = 1'b0; ex_branch_taken = 1'b0; ex_MemRead = 1'b0;
        ex_rd = 5'd0; id_rs1 = 5'd0; id_rs2 = 5'd0; id_uses_rs2 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        idle("reset_idle");

        step("load_use_rs1", V_LOAD, 1'b0, 1'b0, 1'b1, 5'd5, 5'd5, 5'd0, 1'b0);
        idle("after_load_use");

        step("rd_zero", V_IDLE, 1'b0, 1'b0, 1'b1, 5'd0, 5'd0, 5'd0, 1'b1);
        step("rs2_unused", V_IDLE, 1'b0, 1'b0, 1'b1, 5'd5, 5'd3, 5'd5, 1'b0);
        step("rs2_x_unused", V_IDLE, 1'b0, 1'b0, 1'b1, 5'd5, 5'd3, 5'bxxxxx, 1'b0);
        step("load_use_rs2", V_LOAD, 1'b0, 1'b0, 1'b1, 5'd5, 5'd3, 5'd5, 1'b1);
        step("no_load", V_IDLE, 1'b0, 1'b0, 1'b0, 5'd5, 5'd5, 5'd5, 1'b1);

        step("branch_beats_lu", V_BRANCH, 1'b0, 1'b1, 1'b1, 5'd7, 5'd7, 5'd0, 1'b0);
        idle("after_branch");

        for (int i = 1; i <= 3; i++)
            step($sformatf("freeze_br_%0d", i), V_FREEZE, 1'b1, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
        step("branch_after_freeze", V_BRANCH, 1'b0, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);

        step("freeze_lu", V_FREEZE, 1'b1, 1'b0, 1'b1, 5'd9, 5'd9, 5'd0, 1'b0);
        step("lu_after_freeze", V_LOAD, 1'b0, 1'b0, 1'b1, 5'd9, 5'd9, 5'd0, 1'b0);
        idle("idle_mid");

        for (int i = 1; i <= 63; i++)
            step($sformatf("busy63_%0d", i), V_FREEZE, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
        idle("recover_after_63");
        step("branch_after_63", V_BRANCH, 1'b0, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);

        for (int i = 1; i <= 64; i++)
            step($sformatf("busy64_%0d", i), V_FREEZE, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
        step("err_busy_low", V_ERR, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
        step("err_sticky_branch", V_ERR, 1'b0, 1'b1, 1'b1, 5'd7, 5'd7, 5'd0, 1'b0);
        step("err_sticky_busy", V_ERR, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);

        rst = 1'b1;
        step("err_during_rst", V_ERR, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
        rst = 1'b0;
        exp_stall = 16'd0;
        idle("idle_after_rst");
        step("lu_after_rst", V_LOAD, 1'b0, 1'b0, 1'b1, 5'd4, 5'd4, 5'd0, 1'b0);
        idle("final_idle");

        @(negedge clk);
        #1;
        n_checks++;
        if (sb.size() == 0) n_pass++;
        else $display("FAIL scoreboard_drain: got %0d pending want 0", sb.size());

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
